// File: rtl/fft_frame_ctrl.sv
// Frame scheduler in front of fft_sc: ping-pong frame buffer on the write side, unbroken
// FFT_SIZE-sample bursts toward fft_sc, and m_first/m_last framing of the returned stream.
module fft_frame_ctrl #(
    parameter int unsigned FFT_SIZE = 16,
    parameter int unsigned MIN_GAP  = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      s_re,
    input  logic [15:0]      s_im,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [15:0]      fft_din_re,
    output logic [15:0]      fft_din_im,
    output logic             fft_din_valid,
    input  logic [15:0]      fft_dout_re,
    input  logic [15:0]      fft_dout_im,
    input  logic             fft_dout_valid,
    output logic [15:0]      m_re,
    output logic [15:0]      m_im,
    output logic             m_valid,
    output logic             m_first,
    output logic             m_last,
    output logic [CNT_W-1:0] frames_in,
    output logic [CNT_W-1:0] frames_out,
    output logic             err_break
);

    localparam int unsigned     IdxW    = $clog2(FFT_SIZE);
    localparam int unsigned     GapW    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FFT_SIZE - 1);
    localparam logic [GapW-1:0] GapLoad = GapW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    typedef enum logic [1:0] {StIdle, StBurst, StGap} state_e;

    state_e state_q, state_d;

    // Two banks of FFT_SIZE words, addressed {bank, index}; word = {re, im}
    logic [31:0] mem [2*FFT_SIZE];

    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic [IdxW-1:0]  wr_idx_q, wr_idx_d;
    logic             s_ready_q, s_ready_d;
    logic             rd_bank_q;
    logic [IdxW-1:0]  rd_idx_q;
    logic [GapW-1:0]  gap_cnt_q;
    logic [31:0]      din_q;
    logic             din_valid_q;
    logic [CNT_W-1:0] frames_in_q;

    logic             accept;
    logic             wr_done;
    logic             rd_en;
    logic             burst_done;

    logic [15:0]      m_re_q, m_im_q;
    logic             m_valid_q, m_first_q, m_last_q;
    logic [IdxW-1:0]  bin_q;
    logic [CNT_W-1:0] frames_out_q;
    logic             err_q;

    // Write-side handshake and bank bookkeeping; a fill and a free in one cycle both apply
    always_comb begin
        accept    = s_valid && s_ready_q;
        wr_done   = accept && (wr_idx_q == LastIdx);
        full_d    = full_q;
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (burst_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
        wr_bank_d = wr_bank_q ^ wr_done;
        wr_idx_d  = accept ? wr_idx_q + 1'b1 : wr_idx_q;
        s_ready_d = !full_d[wr_bank_d];
    end

    // Write-side state
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            s_ready_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_idx_q  <= wr_idx_d;
            s_ready_q <= s_ready_d;
        end
    end

    // Frame buffer write port (no reset: contents only read after a full fill)
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[{wr_bank_q, wr_idx_q}] <= {s_re, s_im};
        end
    end

    // Issue FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue FSM next state; the last gap cycle launches the next burst directly so bursts are
    // separated by exactly MIN_GAP idle cycles on fft_din_valid
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (full_q[rd_bank_q]) begin
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (rd_idx_q == LastIdx) begin
                    if (MIN_GAP > 0) begin
                        state_d = StGap;
                    end else if (full_q[~rd_bank_q]) begin
                        state_d = StBurst;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == '0) begin
                    state_d = full_q[rd_bank_q] ? StBurst : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Issue FSM outputs
    always_comb begin
        rd_en      = (state_q == StBurst);
        burst_done = rd_en && (rd_idx_q == LastIdx);
    end

    // Read pointer, bank swap, gap timer and issued-frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            gap_cnt_q   <= '0;
            frames_in_q <= '0;
        end else begin
            rd_idx_q <= rd_en ? rd_idx_q + 1'b1 : '0;
            if (burst_done) begin
                rd_bank_q   <= ~rd_bank_q;
                gap_cnt_q   <= GapLoad;
                frames_in_q <= frames_in_q + 1'b1;
            end else if ((state_q == StGap) && (gap_cnt_q != '0)) begin
                gap_cnt_q <= gap_cnt_q - 1'b1;
            end
        end
    end

    // Registered RAM read; data and valid leave aligned one cycle after the read
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q       <= '0;
            din_valid_q <= 1'b0;
        end else begin
            din_valid_q <= rd_en;
            if (rd_en) begin
                din_q <= mem[{rd_bank_q, rd_idx_q}];
            end
        end
    end

    // Result framing: one-cycle copy of fft_dout plus bin tracking and break detection
    always_ff @(posedge clk) begin
        if (rst) begin
            m_re_q       <= '0;
            m_im_q       <= '0;
            m_valid_q    <= 1'b0;
            m_first_q    <= 1'b0;
            m_last_q     <= 1'b0;
            bin_q        <= '0;
            frames_out_q <= '0;
            err_q        <= 1'b0;
        end else begin
            m_re_q    <= fft_dout_re;
            m_im_q    <= fft_dout_im;
            m_valid_q <= fft_dout_valid;
            if (fft_dout_valid) begin
                m_first_q <= (bin_q == '0);
                m_last_q  <= (bin_q == LastIdx);
                bin_q     <= bin_q + 1'b1;
                if (bin_q == LastIdx) begin
                    frames_out_q <= frames_out_q + 1'b1;
                end
            end else begin
                m_first_q <= 1'b0;
                m_last_q  <= 1'b0;
                if (bin_q != '0) begin
                    err_q <= 1'b1;
                    bin_q <= '0;
                end
            end
        end
    end

    assign s_ready       = s_ready_q;
    assign fft_din_re    = din_q[31:16];
    assign fft_din_im    = din_q[15:0];
    assign fft_din_valid = din_valid_q;
    assign m_re          = m_re_q;
    assign m_im          = m_im_q;
    assign m_valid       = m_valid_q;
    assign m_first       = m_first_q;
    assign m_last        = m_last_q;
    assign frames_in     = frames_in_q;
    assign frames_out    = frames_out_q;
    assign err_break     = err_q;

endmodule
